// File: rtl/mouse_packet_decoder.sv
// mouse_packet_decoder: assembles 3-byte PS/2 mouse packets into clamped position, deltas and status.
module mouse_packet_decoder #(
  parameter int MAX_X = 160,
  parameter int MAX_Y = 120,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       STREAM_EN,
  input  logic [7:0] BYTE_IN,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY,
  output logic       READ_ENABLE,
  output logic [7:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_X,
  output logic [7:0] MOUSE_Y,
  output logic [8:0] MOUSE_DX,
  output logic [8:0] MOUSE_DY,
  output logic       SEND_INTERRUPT,
  output logic       PACKET_ERROR
);
  typedef enum logic [2:0] {IDLE, WAIT_B0, WAIT_B1, WAIT_B2, UPDATE} state_t;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state, state_nx;
  logic [TW-1:0] tmo_cnt;
  logic [7:0] b0, b1, b2, x_new, y_new;
  logic [8:0] dx, dy;
  logic [10:0] x_sum, y_sum;
  logic good, bad, wait_b12, timeout, err;
  assign good = BYTE_READY && BYTE_ERROR_CODE == 2'b00;
  assign bad = BYTE_READY && BYTE_ERROR_CODE != 2'b00;
  assign wait_b12 = state == WAIT_B1 || state == WAIT_B2;
  // A byte arriving on the timeout cycle wins over the timeout.
  assign timeout = wait_b12 && !BYTE_READY && tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
  assign READ_ENABLE = state == WAIT_B0 || wait_b12;
  always_comb begin
    state_nx = state;
    err = 1'b0;
    if (!STREAM_EN) state_nx = IDLE;
    else case (state)
      IDLE: state_nx = WAIT_B0;
      WAIT_B0: begin
        err = bad;
        state_nx = (good && BYTE_IN[3]) ? WAIT_B1 : WAIT_B0;
      end
      WAIT_B1: begin
        err = bad || timeout;
        state_nx = good ? WAIT_B2 : err ? WAIT_B0 : WAIT_B1;
      end
      WAIT_B2: begin
        err = bad || timeout;
        state_nx = good ? UPDATE : err ? WAIT_B0 : WAIT_B2;
      end
      UPDATE: state_nx = WAIT_B0;
      default: state_nx = IDLE;
    endcase
  end
  // Overflow bits saturate the delta to +/-255 in the direction of the sign bit.
  assign dx = b0[6] ? (b0[4] ? 9'h101 : 9'h0FF) : {b0[4], b1};
  assign dy = b0[7] ? (b0[5] ? 9'h101 : 9'h0FF) : {b0[5], b2};
  assign x_sum = {3'b000, MOUSE_X} + {{2{dx[8]}}, dx};
  assign y_sum = {3'b000, MOUSE_Y} - {{2{dy[8]}}, dy};
  assign x_new = x_sum[10] ? 8'd0 : (x_sum > 11'(MAX_X - 1)) ? 8'(MAX_X - 1) : x_sum[7:0];
  assign y_new = y_sum[10] ? 8'd0 : (y_sum > 11'(MAX_Y - 1)) ? 8'(MAX_Y - 1) : y_sum[7:0];
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      tmo_cnt <= '0;
      b0 <= 8'd0;
      b1 <= 8'd0;
      b2 <= 8'd0;
      MOUSE_STATUS <= 8'd0;
      MOUSE_X <= 8'(MAX_X / 2);
      MOUSE_Y <= 8'(MAX_Y / 2);
      MOUSE_DX <= 9'd0;
      MOUSE_DY <= 9'd0;
      SEND_INTERRUPT <= 1'b0;
      PACKET_ERROR <= 1'b0;
    end else begin
      state <= state_nx;
      tmo_cnt <= (wait_b12 && !BYTE_READY && state_nx == state) ? tmo_cnt + 1'b1 : '0;
      PACKET_ERROR <= err;
      SEND_INTERRUPT <= state == UPDATE && STREAM_EN;
      if (state == WAIT_B0 && good && BYTE_IN[3]) b0 <= BYTE_IN;
      if (state == WAIT_B1 && good) b1 <= BYTE_IN;
      if (state == WAIT_B2 && good) b2 <= BYTE_IN;
      if (state == UPDATE && STREAM_EN) begin
        MOUSE_STATUS <= b0;
        MOUSE_DX <= dx;
        MOUSE_DY <= dy;
        MOUSE_X <= x_new;
        MOUSE_Y <= y_new;
      end
    end
  end
endmodule

// File: tb/tb_mouse_packet_decoder.sv
// tb_mouse_packet_decoder: directed scenarios for the PS/2 mouse packet decoder.
module tb_mouse_packet_decoder;
  localparam int T = 20;
  logic CLK = 1'b0, RESET = 1'b1, STREAM_EN = 1'b1, BYTE_READY = 1'b0;
  logic [7:0] BYTE_IN = 8'd0;
  logic [1:0] BYTE_ERROR_CODE = 2'd0;
  logic READ_ENABLE, SEND_INTERRUPT, PACKET_ERROR;
  logic [7:0] MOUSE_STATUS, MOUSE_X, MOUSE_Y;
  logic [8:0] MOUSE_DX, MOUSE_DY;
  int total = 0, bad = 0, si_tot = 0, pe_tot = 0;
  mouse_packet_decoder #(.MAX_X(160), .MAX_Y(120), .TIMEOUT_CYCLES(T)) dut (
    .CLK(CLK), .RESET(RESET), .STREAM_EN(STREAM_EN), .BYTE_IN(BYTE_IN),
    .BYTE_ERROR_CODE(BYTE_ERROR_CODE), .BYTE_READY(BYTE_READY), .READ_ENABLE(READ_ENABLE),
    .MOUSE_STATUS(MOUSE_STATUS), .MOUSE_X(MOUSE_X), .MOUSE_Y(MOUSE_Y), .MOUSE_DX(MOUSE_DX),
    .MOUSE_DY(MOUSE_DY), .SEND_INTERRUPT(SEND_INTERRUPT), .PACKET_ERROR(PACKET_ERROR)
  );
  always #5 CLK = ~CLK;
  always @(negedge CLK) begin
    if (SEND_INTERRUPT) si_tot++;
    if (PACKET_ERROR) pe_tot++;
  end
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic send(input logic [7:0] b, input logic [1:0] c);
    BYTE_IN = b;
    BYTE_ERROR_CODE = c;
    BYTE_READY = 1'b1;
    tick();
    BYTE_READY = 1'b0;
    BYTE_ERROR_CODE = 2'd0;
  endtask
  task automatic packet(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send(a, 2'd0);
    send(b, 2'd0);
    send(c, 2'd0);
  endtask
  task automatic do_reset();
    RESET = 1'b1;
    STREAM_EN = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
  endtask
  task automatic start();
    do_reset();
    tick();
  endtask
  task automatic test_reset();
    do_reset();
    total++; if (MOUSE_X !== 8'd80) begin bad++; $display("FAIL rst_x got=%0d exp=80", MOUSE_X); end
    total++; if (MOUSE_Y !== 8'd60) begin bad++; $display("FAIL rst_y got=%0d exp=60", MOUSE_Y); end
    total++; if (MOUSE_STATUS !== 8'h00) begin bad++; $display("FAIL rst_status got=%h exp=00", MOUSE_STATUS); end
    total++; if (MOUSE_DX !== 9'h000 || MOUSE_DY !== 9'h000) begin bad++; $display("FAIL rst_d got=%h/%h exp=0/0", MOUSE_DX, MOUSE_DY); end
    total++; if (SEND_INTERRUPT !== 1'b0 || PACKET_ERROR !== 1'b0) begin bad++; $display("FAIL rst_strobes got=%b%b exp=00", SEND_INTERRUPT, PACKET_ERROR); end
    total++; if (READ_ENABLE !== 1'b0) begin bad++; $display("FAIL rst_idle_re got=%b exp=0", READ_ENABLE); end
    tick();
    total++; if (READ_ENABLE !== 1'b1) begin bad++; $display("FAIL rst_wait_b0_re got=%b exp=1", READ_ENABLE); end
  endtask
  task automatic test_basic();
    start();
    packet(8'h08, 8'h05, 8'h03);
    total++; if (SEND_INTERRUPT !== 1'b0 || MOUSE_X !== 8'd80 || READ_ENABLE !== 1'b0) begin bad++; $display("FAIL basic_update_cycle got si=%b x=%0d re=%b exp si=0 x=80 re=0", SEND_INTERRUPT, MOUSE_X, READ_ENABLE); end
    tick();
    total++; if (SEND_INTERRUPT !== 1'b1 || PACKET_ERROR !== 1'b0) begin bad++; $display("FAIL basic_si got=%b%b exp=10", SEND_INTERRUPT, PACKET_ERROR); end
    total++; if (MOUSE_X !== 8'd85 || MOUSE_Y !== 8'd57) begin bad++; $display("FAIL basic_pos got=%0d,%0d exp=85,57", MOUSE_X, MOUSE_Y); end
    total++; if (MOUSE_DX !== 9'h005 || MOUSE_DY !== 9'h003 || MOUSE_STATUS !== 8'h08) begin bad++; $display("FAIL basic_delta got=%h,%h,%h exp=005,003,08", MOUSE_DX, MOUSE_DY, MOUSE_STATUS); end
    tick();
    total++; if (SEND_INTERRUPT !== 1'b0) begin bad++; $display("FAIL basic_si_width got=%b exp=0", SEND_INTERRUPT); end
  endtask
  task automatic test_negative();
    start();
    packet(8'h18, 8'hFB, 8'h00);
    tick();
    total++; if (MOUSE_DX !== 9'h1FB || MOUSE_X !== 8'd75) begin bad++; $display("FAIL neg_dx got=%h,%0d exp=1fb,75", MOUSE_DX, MOUSE_X); end
    packet(8'h58, 8'h00, 8'h00);
    tick();
    total++; if (MOUSE_DX !== 9'h101 || MOUSE_X !== 8'd0 || MOUSE_Y !== 8'd60) begin bad++; $display("FAIL neg_sat got=%h,%0d,%0d exp=101,0,60", MOUSE_DX, MOUSE_X, MOUSE_Y); end
    packet(8'h48, 8'h00, 8'h00);
    tick();
    total++; if (MOUSE_DX !== 9'h0FF || MOUSE_X !== 8'd159) begin bad++; $display("FAIL pos_sat got=%h,%0d exp=0ff,159", MOUSE_DX, MOUSE_X); end
  endtask
  task automatic test_y_clamp();
    start();
    packet(8'h28, 8'h00, 8'h80);
    tick();
    total++; if (MOUSE_DY !== 9'h180 || MOUSE_Y !== 8'd119) begin bad++; $display("FAIL y_bottom got=%h,%0d exp=180,119", MOUSE_DY, MOUSE_Y); end
    packet(8'h88, 8'h00, 8'h00);
    tick();
    total++; if (MOUSE_DY !== 9'h0FF || MOUSE_Y !== 8'd0) begin bad++; $display("FAIL y_top got=%h,%0d exp=0ff,0", MOUSE_DY, MOUSE_Y); end
  endtask
  task automatic test_resync();
    int pe0;
    start();
    pe0 = pe_tot;
    send(8'h07, 2'd0);
    packet(8'h08, 8'h01, 8'h01);
    tick();
    total++; if (MOUSE_X !== 8'd81 || MOUSE_Y !== 8'd59 || SEND_INTERRUPT !== 1'b1) begin bad++; $display("FAIL resync got=%0d,%0d si=%b exp=81,59 si=1", MOUSE_X, MOUSE_Y, SEND_INTERRUPT); end
    total++; if (pe_tot !== pe0) begin bad++; $display("FAIL resync_pe got=%0d exp=%0d", pe_tot, pe0); end
  endtask
  task automatic test_error();
    start();
    send(8'h08, 2'd0);
    send(8'h05, 2'd1);
    total++; if (PACKET_ERROR !== 1'b1 || SEND_INTERRUPT !== 1'b0) begin bad++; $display("FAIL err_pulse got=%b%b exp=10", PACKET_ERROR, SEND_INTERRUPT); end
    tick();
    total++; if (PACKET_ERROR !== 1'b0 || MOUSE_X !== 8'd80 || MOUSE_DX !== 9'h000) begin bad++; $display("FAIL err_hold got pe=%b x=%0d dx=%h exp 0,80,000", PACKET_ERROR, MOUSE_X, MOUSE_DX); end
    packet(8'h08, 8'h00, 8'h00);
    tick();
    total++; if (SEND_INTERRUPT !== 1'b1 || MOUSE_X !== 8'd80 || MOUSE_STATUS !== 8'h08) begin bad++; $display("FAIL err_recover got si=%b x=%0d st=%h exp 1,80,08", SEND_INTERRUPT, MOUSE_X, MOUSE_STATUS); end
    send(8'h08, 2'd2);
    total++; if (PACKET_ERROR !== 1'b1) begin bad++; $display("FAIL err_b0 got=%b exp=1", PACKET_ERROR); end
  endtask
  task automatic test_timeout();
    int pe0;
    start();
    send(8'h08, 2'd0);
    repeat (T - 1) tick();
    total++; if (PACKET_ERROR !== 1'b0) begin bad++; $display("FAIL tmo_early got=%b exp=0", PACKET_ERROR); end
    tick();
    total++; if (PACKET_ERROR !== 1'b1 || READ_ENABLE !== 1'b1) begin bad++; $display("FAIL tmo_fire got pe=%b re=%b exp 1,1", PACKET_ERROR, READ_ENABLE); end
    packet(8'h08, 8'h02, 8'h03);
    tick();
    total++; if (MOUSE_X !== 8'd82 || MOUSE_Y !== 8'd57) begin bad++; $display("FAIL tmo_recover got=%0d,%0d exp=82,57", MOUSE_X, MOUSE_Y); end
    start();
    pe0 = pe_tot;
    send(8'h08, 2'd0);
    repeat (T - 1) tick();
    send(8'h05, 2'd0);
    send(8'h03, 2'd0);
    tick();
    total++; if (SEND_INTERRUPT !== 1'b1 || MOUSE_X !== 8'd85 || MOUSE_Y !== 8'd57) begin bad++; $display("FAIL tmo_exact got si=%b pos=%0d,%0d exp 1,85,57", SEND_INTERRUPT, MOUSE_X, MOUSE_Y); end
    total++; if (pe_tot !== pe0) begin bad++; $display("FAIL tmo_exact_pe got=%0d exp=%0d", pe_tot, pe0); end
  endtask
  task automatic test_stream_drop();
    int si0, pe0;
    start();
    si0 = si_tot;
    pe0 = pe_tot;
    send(8'h08, 2'd0);
    send(8'h05, 2'd0);
    STREAM_EN = 1'b0;
    tick();
    total++; if (READ_ENABLE !== 1'b0) begin bad++; $display("FAIL drop_re got=%b exp=0", READ_ENABLE); end
    send(8'h03, 2'd0);
    repeat (3) tick();
    total++; if (si_tot !== si0 || pe_tot !== pe0 || MOUSE_X !== 8'd80 || MOUSE_DX !== 9'h000) begin bad++; $display("FAIL drop_hold got si=%0d pe=%0d x=%0d dx=%h exp si=%0d pe=%0d x=80 dx=000", si_tot, pe_tot, MOUSE_X, MOUSE_DX, si0, pe0); end
    STREAM_EN = 1'b1;
    tick();
    total++; if (READ_ENABLE !== 1'b1) begin bad++; $display("FAIL drop_resume_re got=%b exp=1", READ_ENABLE); end
    packet(8'h08, 8'h01, 8'h01);
    tick();
    total++; if (MOUSE_X !== 8'd81 || MOUSE_Y !== 8'd59 || SEND_INTERRUPT !== 1'b1) begin bad++; $display("FAIL drop_resume got=%0d,%0d si=%b exp=81,59 si=1", MOUSE_X, MOUSE_Y, SEND_INTERRUPT); end
  endtask
  task automatic test_reset_mid_packet();
    start();
    send(8'h08, 2'd0);
    send(8'h05, 2'd0);
    do_reset();
    total++; if (READ_ENABLE !== 1'b0 || MOUSE_X !== 8'd80) begin bad++; $display("FAIL midrst got re=%b x=%0d exp 0,80", READ_ENABLE, MOUSE_X); end
    tick();
    send(8'h03, 2'd0);
    packet(8'h08, 8'h01, 8'h01);
    tick();
    total++; if (MOUSE_X !== 8'd81 || MOUSE_Y !== 8'd59) begin bad++; $display("FAIL midrst_discard got=%0d,%0d exp=81,59", MOUSE_X, MOUSE_Y); end
  endtask
  initial begin
    #1;
    test_reset();
    test_basic();
    test_negative();
    test_y_clamp();
    test_resync();
    test_error();
    test_timeout();
    test_stream_drop();
    test_reset_mid_packet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mouse_packet_decoder.md
MOUSE_PACKET_DECODER -- requirements
Module: mouse_packet_decoder

Interface
REQ-001 Parameter MAX_X, default 160: horizontal position range; MOUSE_X stays in 0..MAX_X-1.
REQ-002 Parameter MAX_Y, default 120: vertical position range; MOUSE_Y stays in 0..MAX_Y-1.
REQ-003 Parameter TIMEOUT_CYCLES, default 200000: inter-byte timeout in CLK cycles.
REQ-004 CLK  input  1  system clock; all state changes on its rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 STREAM_EN  input  1  high once the mouse is initialised and in stream mode.
REQ-007 BYTE_IN  input  8  received byte from the PS/2 byte receiver.
REQ-008 BYTE_ERROR_CODE  input  2  receiver status; bit0 parity error, bit1 stop-bit error.
REQ-009 BYTE_READY  input  1  one-cycle strobe: BYTE_IN and BYTE_ERROR_CODE are valid.
REQ-010 READ_ENABLE  output  1  enables the byte receiver.
REQ-011 MOUSE_STATUS  output  8  byte 0 of the last good packet.
REQ-012 MOUSE_X  output  8  clamped horizontal position.
REQ-013 MOUSE_Y  output  8  clamped vertical position, 0 = top.
REQ-014 MOUSE_DX  output  9  signed X delta of the last good packet.
REQ-015 MOUSE_DY  output  9  signed Y delta of the last good packet (PS/2 sense, + = up).
REQ-016 SEND_INTERRUPT  output  1  one-cycle strobe: new packet applied.
REQ-017 PACKET_ERROR  output  1  one-cycle strobe: packet discarded.

Function
REQ-018 States SHALL be IDLE, WAIT_B0, WAIT_B1, WAIT_B2, UPDATE.
REQ-019 IDLE -> WAIT_B0 when STREAM_EN=1; any state -> IDLE when STREAM_EN=0, discarding partial bytes, holding outputs, and raising no strobe.
REQ-020 READ_ENABLE SHALL be 1 in WAIT_B0, WAIT_B1 and WAIT_B2, and 0 in IDLE and UPDATE.
REQ-021 WAIT_B0: on BYTE_READY with code 00 and BYTE_IN[3]=1 -> latch as status and go to WAIT_B1; BYTE_IN[3]=0 -> silently discard and stay (resync); code!=00 -> PACKET_ERROR, stay.
REQ-022 WAIT_B1/WAIT_B2: on BYTE_READY with code 00 -> latch X/Y byte and advance; code!=00 -> PACKET_ERROR and return to WAIT_B0.
REQ-023 Timeout counter SHALL clear on every accepted byte and on entry to WAIT_B1; in WAIT_B1/WAIT_B2, reaching TIMEOUT_CYCLES -> PACKET_ERROR and return to WAIT_B0.
REQ-024 BYTE_READY and timeout in the same cycle: the byte SHALL take priority.
REQ-025 UPDATE SHALL last exactly one cycle, ignore BYTE_READY, then return to WAIT_B0.
REQ-026 DX SHALL be {status[4], byte1}, 9-bit two's complement.
REQ-027 If status[6]=1, DX SHALL saturate to -255 when status[4]=1 and to +255 otherwise.
REQ-028 DY SHALL follow the same rules using status[5], byte2 and status[7].
REQ-029 X update: X_new = clamp(X + DX, 0, MAX_X-1), computed at 10+ bit signed width with no wrap.
REQ-030 Y update: Y_new = clamp(Y - DY, 0, MAX_Y-1).
REQ-031 MOUSE_STATUS, MOUSE_DX, MOUSE_DY, MOUSE_X and MOUSE_Y SHALL update at the edge that ends UPDATE; SEND_INTERRUPT SHALL be high for the following cycle only.
REQ-032 Latency: third-byte BYTE_READY in cycle t -> UPDATE in t+1 -> new outputs and SEND_INTERRUPT in t+2.
REQ-033 Outputs SHALL change only on UPDATE, except under RESET.
REQ-034 PACKET_ERROR and SEND_INTERRUPT SHALL never be high together.

Reset
REQ-035 Under RESET: state IDLE; MOUSE_X = MAX_X/2 (80); MOUSE_Y = MAX_Y/2 (60); MOUSE_STATUS, MOUSE_DX and MOUSE_DY = 0; strobes 0; READ_ENABLE 0; timeout counter 0.
REQ-036 RESET mid-packet SHALL discard partial bytes; the decoder SHALL be in IDLE on the cycle after RESET is released.

Verification
REQ-037 After reset with STREAM_EN=1, send 08,05,03 -> X=85, Y=57, DX=+5, DY=+3, SEND_INTERRUPT one cycle at t+2.
REQ-038 Send 18,FB,00 -> DX=-5, X=75; then 58,00,00 (X overflow, negative) -> DX=-255, X=0 (clamped).
REQ-039 Send 07 (bit3=0) then 08,01,01 -> 07 ignored, no PACKET_ERROR, X=81, Y=59.
REQ-040 Send 08, then byte 2 with code 01 -> PACKET_ERROR pulse, positions unchanged; next 08,00,00 is accepted normally.
REQ-041 Send 08, then idle for TIMEOUT_CYCLES -> PACKET_ERROR, state WAIT_B0; a BYTE_READY on the exact timeout cycle is accepted instead.
REQ-042 Drop STREAM_EN after byte 1 -> IDLE, READ_ENABLE=0, no strobes, outputs held.
